// File: rtl/quad_pkg.sv
// -----------------------------------------------------------------------------
// quad_pkg
// Shared types, constants and helpers for the quadrature decoder.
//   phase_idx_t  : 2-bit electrical phase index of an {a,b} pair
//   ab_to_idx()  : maps the Gray-coded {a,b} pair onto a linear phase index
//   DIR_FWD/REV  : encoding of the direction output
//   quad_state_t : decoder control FSM states
// -----------------------------------------------------------------------------
package quad_pkg;

  typedef logic [1:0] phase_idx_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic {
    INIT,
    RUN
  } quad_state_t;

  // Forward rotation walks 11 -> 01 -> 00 -> 10 -> 11, so the index rises by
  // one (mod 4) per forward step and the difference of two indices tells the
  // direction without a lookup table of transitions.
  function automatic phase_idx_t ab_to_idx(input logic [1:0] ab);
    phase_idx_t idx;
    case (ab)
      2'b11:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b00:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// -----------------------------------------------------------------------------
// quad_input_filter
// Two-flop synchronizer followed by a stability filter on a W-bit group of
// asynchronous pins. A new level is accepted only after the synchronized group
// has held the same value for FILT_LEN consecutive cycles.
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   din       in   W  raw asynchronous pins
//   filt      out  W  accepted (filtered) level
//   filt_prev out  W  accepted level before the most recent change
//   changed   out  1  one-cycle pulse when filt took a new, different value
//   valid     out  1  set once the first stable level has been loaded
//
// The very first stable level is loaded silently (valid rises, no changed
// pulse) so the consumer can initialise without seeing a spurious transition.
// -----------------------------------------------------------------------------
module quad_input_filter #(
  parameter int W        = 2,
  parameter int FILT_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] filt,
  output logic [W-1:0] filt_prev,
  output logic         changed,
  output logic         valid
);

  localparam int CNT_W = $clog2(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [W-1:0]     cand;     // previous synchronized sample
  logic [1:0]       prime;    // marks when sync2 holds real pin data
  logic [CNT_W-1:0] run_cnt;  // consecutive equal samples seen, minus one
  logic             stable;

  // This sample completes a run of FILT_LEN identical samples.
  assign stable = prime[1] && (sync2 == cand) && (run_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      cand      <= '0;
      prime     <= '0;
      run_cnt   <= '0;
      filt      <= '0;
      filt_prev <= '0;
      changed   <= 1'b0;
      valid     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge value of the others, which is what forms the flop chain.
      sync1   <= din;
      sync2   <= sync1;
      cand    <= sync2;
      prime   <= {prime[0], 1'b1};
      changed <= 1'b0;

      // Reset zeros in the synchronizer must not count as a stable level.
      if (!prime[1]) begin
        run_cnt <= '0;
      end else if (sync2 != cand) begin
        run_cnt <= CNT_W'(1);
      end else if (run_cnt != CNT_LAST) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end

      if (stable) begin
        if (!valid) begin
          filt  <= sync2;
          valid <= 1'b1;
        end else if (sync2 != filt) begin
          filt      <= sync2;
          filt_prev <= filt;
          changed   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
// Decodes two-phase (A/B) quadrature signals into a signed position count,
// per-step pulses, a direction flag and a windowed velocity.
// Forward sequence (a,b) = 11 -> 01 -> 00 -> 10 -> 11 counts up.
//
// Parameters
//   POS_W    position width (two's complement, wraps)
//   FILT_LEN consecutive stable cycles to accept a new input level (>= 2)
//   VEL_WIN  clocks per velocity window
//   VEL_W    velocity width (signed, saturating)
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   enc_a       in   phase A (asynchronous)
//   enc_b       in   phase B (asynchronous)
//   enc_z       in   index channel (asynchronous, QUAD_INDEX_EN only)
//   clear       in   synchronous position clear
//   position    out  POS_W signed step count
//   step_pulse  out  one-cycle pulse per accepted step
//   direction   out  direction of last step (1 = forward)
//   err_pulse   out  one-cycle pulse on an illegal two-bit jump
//   index_pulse out  one-cycle pulse on a filtered Z rising edge
//                    (QUAD_INDEX_EN only)
//   velocity    out  VEL_W signed steps counted in the last window
//   vel_valid   out  one-cycle pulse when velocity updates
//
// Build option: define QUAD_INDEX_EN to add the Z index channel, which zeroes
// the position on each filtered rising edge of enc_z.
//
// Latency: a level first sampled at edge N is visible on step_pulse/position
// after edge N+2+FILT_LEN (2 sync flops, FILT_LEN filter, output register).
// -----------------------------------------------------------------------------
module quad_decoder
  import quad_pkg::*;
#(
  parameter int POS_W    = 16,
  parameter int FILT_LEN = 4,
  parameter int VEL_WIN  = 27000,
  parameter int VEL_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
`ifdef QUAD_INDEX_EN
  input  logic             enc_z,
`endif
  input  logic             clear,
  output logic [POS_W-1:0] position,
  output logic             step_pulse,
  output logic             direction,
  output logic             err_pulse,
`ifdef QUAD_INDEX_EN
  output logic             index_pulse,
`endif
  output logic [VEL_W-1:0] velocity,
  output logic             vel_valid
);

  localparam int WIN_W = $clog2(VEL_WIN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WIN - 1);
  localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] VEL_MIN = -VEL_MAX;

  quad_state_t state;
  quad_state_t state_next;

  logic [1:0] ab_filt;
  logic [1:0] ab_prev;
  logic       ab_changed;
  logic       ab_valid;

  phase_idx_t delta;
  logic       step_fwd;
  logic       step_rev;
  logic       step_err;
  logic       pos_zero;
  logic [POS_W-1:0] pos_next;

  logic [WIN_W-1:0]        win_cnt;
  logic                    win_last;
  logic signed [VEL_W-1:0] vel_acc;
  logic signed [VEL_W-1:0] acc_next;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  quad_input_filter #(
    .W        (2),
    .FILT_LEN (FILT_LEN)
  ) u_ab_filter (
    .clk       (clk),
    .rst       (rst),
    .din       ({enc_a, enc_b}),
    .filt      (ab_filt),
    .filt_prev (ab_prev),
    .changed   (ab_changed),
    .valid     (ab_valid)
  );

`ifdef QUAD_INDEX_EN
  logic z_filt;
  logic z_prev;
  logic z_changed;
  logic z_valid;
  logic z_rise;

  quad_input_filter #(
    .W        (1),
    .FILT_LEN (FILT_LEN)
  ) u_z_filter (
    .clk       (clk),
    .rst       (rst),
    .din       (enc_z),
    .filt      (z_filt),
    .filt_prev (z_prev),
    .changed   (z_changed),
    .valid     (z_valid)
  );

  assign z_rise   = (state == RUN) && z_valid && z_changed && z_filt && !z_prev;
  // Index and clear both force zero, and both outrank a concurrent step.
  assign pos_zero = clear || z_rise;
`else
  assign pos_zero = clear;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: hold off decoding until the first stable level is loaded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // signal unassigned, which would otherwise infer a latch.
    state_next = state;
    case (state)
      INIT:    if (ab_valid) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Step decode: the modular index difference classifies the transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    delta    = ab_to_idx(ab_filt) - ab_to_idx(ab_prev);
    step_fwd = 1'b0;
    step_rev = 1'b0;
    step_err = 1'b0;
    if ((state == RUN) && ab_changed) begin
      case (delta)
        2'd1:    step_fwd = 1'b1;
        2'd3:    step_rev = 1'b1;
        2'd2:    step_err = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    pos_next = position;
    if (step_fwd) begin
      pos_next = position + POS_W'(1);
    end else if (step_rev) begin
      pos_next = position - POS_W'(1);
    end
    if (pos_zero) begin
      pos_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Velocity: saturating per-window step accumulator. The step decoded on the
  // last window cycle still belongs to that window.
  // ---------------------------------------------------------------------------
  assign win_last = (win_cnt == WIN_LAST);

  always_comb begin
    acc_next = vel_acc;
    if (step_fwd && (vel_acc != VEL_MAX)) begin
      acc_next = vel_acc + VEL_W'(1);
    end else if (step_rev && (vel_acc != VEL_MIN)) begin
      acc_next = vel_acc - VEL_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      position   <= '0;
      step_pulse <= 1'b0;
      direction  <= DIR_REV;
      err_pulse  <= 1'b0;
      velocity   <= '0;
      vel_valid  <= 1'b0;
      win_cnt    <= '0;
      vel_acc    <= '0;
`ifdef QUAD_INDEX_EN
      index_pulse <= 1'b0;
`endif
    end else begin
      position   <= pos_next;
      step_pulse <= step_fwd | step_rev;
      err_pulse  <= step_err;
      if (step_fwd) begin
        direction <= DIR_FWD;
      end else if (step_rev) begin
        direction <= DIR_REV;
      end
`ifdef QUAD_INDEX_EN
      index_pulse <= z_rise;
`endif

      vel_valid <= win_last;
      if (win_last) begin
        win_cnt  <= '0;
        velocity <= acc_next;
        vel_acc  <= '0;
      end else begin
        win_cnt  <= win_cnt + WIN_W'(1);
        vel_acc  <= acc_next;
      end
    end
  end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Reads the two-phase (A/B) quadrature signals of a motor-shaft encoder or a monitored stepper phase pair, and converts them to a signed position count, per-step pulses, direction, and a windowed velocity.
- It is the inverse of the stepper phase generator: forward sequence (a,b) = 11→01→00→10→11 counts up, matching direction=1 on the drive side.
- Sits between the encoder pins and the motion-control logic on the Tang Nano 9K.

Parameters:
- POS_W, 16, position counter width (two's complement, wraps).
- FILT_LEN, 4, consecutive stable cycles required to accept a new input level (≥2).
- VEL_WIN, 27000, clocks per velocity window (1 ms at 27 MHz).
- VEL_W, 12, velocity output width (signed, saturating).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- enc_a  input  1  phase A, asynchronous.
- enc_b  input  1  phase B, asynchronous.
- clear  input  1  synchronous position clear.
- position  output  POS_W  signed step count.
- step_pulse  output  1  one-cycle pulse per accepted step.
- direction  output  1  direction of last step: 1=forward, 0=reverse.
- err_pulse  output  1  one-cycle pulse on an illegal two-bit jump.
- velocity  output  VEL_W  signed steps counted in the last window.
- vel_valid  output  1  one-cycle pulse when velocity updates.

Behaviour:
- Reset: all outputs 0; FSM→INIT; window counter and accumulator 0.
- Input path:
  - 2-FF synchronizer per channel.
  - Filter on the {a,b} pair: the candidate pair is accepted into filt_ab after being stable and different from filt_ab for FILT_LEN consecutive cycles.
  - Any change restarts the stability count.
- Phase index: 11→0, 01→1, 00→2, 10→3. On acceptance, delta = (new − old) mod 4:
  - 1 → +1: step_pulse=1, direction=1.
  - 3 → −1: step_pulse=1, direction=0.
  - 2 → err_pulse=1. No step. Position and direction unchanged. filt_ab still updates.
- FSM:
  - INIT: wait until the synchronized pair has been stable for FILT_LEN cycles, then load filt_ab with no pulse and go to RUN.
  - RUN: normal decoding.
  - rst in any state returns to INIT.
- Latency: level first sampled at clk edge N → step_pulse/position update visible after edge N+2+FILT_LEN (registered outputs).
- Position:
  - Wraps modulo 2^POS_W (e.g. 0xFFFF +1 → 0x0000; 0x0000 −1 → 0xFFFF).
  - clear coincident with a step: clear wins and position=0. step_pulse and direction still reflect that step.
- Velocity:
  - Free-running window counter 0..VEL_WIN−1.
  - Signed accumulator adds ±1 per step, saturating at ±(2^(VEL_W−1)−1).
  - On the last window cycle: velocity ← accumulator plus that cycle's step, vel_valid=1, accumulator←0.
  - clear does not affect velocity.
  - Counter runs in INIT, where accumulation is 0.
- err_pulse and step_pulse are never high together.

Optional Feature:
- Macro QUAD_INDEX_EN.
- Defined:
  - Adds input enc_z (index) and output index_pulse.
  - enc_z passes through the same synchronizer/filter path.
  - On a filtered rising edge of Z in RUN: position←0, index_pulse=1 for one cycle.
  - Z reset outranks a simultaneous step; clear and Z together → 0.
- Undefined: ports and logic absent; behaviour as above.

Decomposition:
- Package quad_pkg holds:
  - typedef phase_idx_t (logic[1:0]).
  - Function ab_to_idx.
  - Localparams DIR_FWD=1, DIR_REV=0.
  - FSM enum {INIT, RUN}.
- Sub-module quad_input_filter: synchronizer plus FILT_LEN stability filter, parameterized width. Instantiated once for {a,b}, and once for z under QUAD_INDEX_EN.

Test Plan:
1. Reset, hold ab=11 for 10 clks, then step 11→01→00→10→11 with each level held 8 clks (FILT_LEN=4) → 4 step_pulses, direction=1, position=4. Each pulse occurs exactly 6 clks after its level change is first sampled.
2. From position 4, reverse 11→10→00→01 → 3 pulses, direction=0, position=1.
3. 2-clk glitch on enc_a, then 3-clk glitch on enc_a (both shorter than FILT_LEN) → no step_pulse, no err_pulse, position unchanged.
4. Jump ab 11→00 held 8 clks → err_pulse exactly once, position unchanged, next 00→10 counts +1.
5. Preload to 0xFFFF via steps or force, one forward step → position 0x0000. Then clear asserted in the same cycle as a step → position 0, step_pulse=1.
6. VEL_WIN=100: 7 forward steps in the window → vel_valid at cycle 99, velocity=7; next window with 3 reverse steps → velocity=−3 (0xFFD).
